// File: rtl/packet_sched_pkg.sv
// Shared types and id helpers for the HDMI data-island packet slot scheduler.
// Grant id map: 0 = NULL packet, 1..N_URGENT = urgent sources, then periodic sources.
package packet_sched_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } sched_state_e;

    localparam int SLOT_LEN = 32;
    localparam int NULL_ID  = 0;

    function automatic int urgent_id(input int idx);
        return idx + 1;
    endfunction

    function automatic int periodic_id(input int idx, input int n_urgent);
        return n_urgent + 1 + idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set mask bit at or after
// ptr, wrapping at N. The pointer register lives in the caller.
module rr_picker #(
    parameter int N     = 8,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] index
);

    int k;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        index = '0;
        k     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N;
            if (mask[k]) begin
                found = 1'b1;
                index = PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/packet_slot_scheduler.sv
// Grants one HDMI data-island packet slot per packet_enable: urgent fixed priority,
// then once-per-field periodic sources round-robin, else NULL. Optional macro:
// PACKET_SCHED_STARVATION_GUARD_EN bounds urgent streaks while periodic work waits.
module packet_slot_scheduler
    import packet_sched_pkg::*;
#(
    parameter int N_URGENT          = 2,
    parameter int N_PERIODIC        = 8,
    parameter int URGENT_STREAK_MAX = 4,
    parameter int ID_W              = $clog2(N_URGENT + N_PERIODIC + 1)
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic                  video_field_end,
    input  logic                  packet_enable,
    input  logic [N_URGENT-1:0]   urgent_req,
    input  logic [N_PERIODIC-1:0] periodic_en,
    output logic [N_URGENT-1:0]   urgent_ack,
    output logic                  grant_valid,
    output logic [ID_W-1:0]       grant_id,
    output logic                  slot_active,
    output logic                  missed_field,
    output logic                  protocol_error
);

    localparam int PTR_W = (N_PERIODIC > 1) ? $clog2(N_PERIODIC) : 1;
    localparam int CNT_W = $clog2(SLOT_LEN);

    sched_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_PERIODIC-1:0] pending_q, pending_d, avail;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d, rr_idx;
    logic                  rr_found;
    logic [N_URGENT-1:0]   urgent_ack_q, urgent_ack_d, urg_onehot;
    logic                  grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]       grant_id_q, grant_id_d, urg_id;
    logic                  missed_q, missed_d;
    logic                  perr_q, perr_d;
    logic                  urg_found, accept, force_periodic;

    // A field-end reload in the same cycle as a strobe is visible to that arbitration.
    assign avail  = (video_field_end ? periodic_en : pending_q) & periodic_en;
    assign accept = (state_q == ST_IDLE) && packet_enable;

    rr_picker #(.N(N_PERIODIC), .PTR_W(PTR_W)) u_rr_picker (
        .mask  (avail),
        .ptr   (rr_ptr_q),
        .found (rr_found),
        .index (rr_idx)
    );

    always_comb begin
        urg_found  = 1'b0;
        urg_id     = '0;
        urg_onehot = '0;
        for (int i = N_URGENT - 1; i >= 0; i--) begin
            if (urgent_req[i]) begin
                urg_found     = 1'b1;
                urg_id        = ID_W'(urgent_id(i));
                urg_onehot    = '0;
                urg_onehot[i] = 1'b1;
            end
        end
    end

`ifdef PACKET_SCHED_STARVATION_GUARD_EN
    localparam int STREAK_W = $clog2(URGENT_STREAK_MAX + 1);
    logic [STREAK_W-1:0] streak_q, streak_d;

    assign force_periodic = rr_found && (streak_q >= STREAK_W'(URGENT_STREAK_MAX));

    // Only urgent grants that jump ahead of waiting periodic work extend the streak.
    always_comb begin
        streak_d = streak_q;
        if (accept) begin
            if (urg_found && !force_periodic) begin
                if (rr_found) streak_d = streak_q + 1'b1;
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) streak_q <= '0;
        else       streak_q <= streak_d;
    end
`else
    assign force_periodic = (URGENT_STREAK_MAX < 0);
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pending_d     = video_field_end ? periodic_en : pending_q;
        rr_ptr_d      = rr_ptr_q;
        urgent_ack_d  = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = ID_W'(NULL_ID);
        missed_d      = video_field_end && (|(pending_q & periodic_en));
        perr_d        = perr_q | ((state_q == ST_SLOT) && packet_enable);

        if (state_q == ST_SLOT) begin
            if (cnt_q == CNT_W'(SLOT_LEN - 1)) state_d = ST_IDLE;
            else                               cnt_d   = cnt_q + 1'b1;
        end else if (accept) begin
            state_d       = ST_SLOT;
            cnt_d         = '0;
            grant_valid_d = 1'b1;
            if (urg_found && !force_periodic) begin
                grant_id_d   = urg_id;
                urgent_ack_d = urg_onehot;
            end else if (rr_found) begin
                grant_id_d        = ID_W'(periodic_id(int'(rr_idx), N_URGENT));
                pending_d[rr_idx] = 1'b0;
                rr_ptr_d          = (rr_idx == PTR_W'(N_PERIODIC - 1)) ? '0 : rr_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pending_q     <= '0;
            rr_ptr_q      <= '0;
            urgent_ack_q  <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            missed_q      <= 1'b0;
            perr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            rr_ptr_q      <= rr_ptr_d;
            urgent_ack_q  <= urgent_ack_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            missed_q      <= missed_d;
            perr_q        <= perr_d;
        end
    end

    assign urgent_ack     = urgent_ack_q;
    assign grant_valid    = grant_valid_q;
    assign grant_id       = grant_id_q;
    assign slot_active    = (state_q == ST_SLOT);
    assign missed_field   = missed_q;
    assign protocol_error = perr_q;

endmodule

// File: tb/tb_packet_slot_scheduler.sv
// Self-checking bench for packet_slot_scheduler: directed plan steps, then randomized
// traffic against a behavioural slot/field model (honours PACKET_SCHED_STARVATION_GUARD_EN).
module tb_packet_slot_scheduler;

    localparam int NU   = 2;
    localparam int NP   = 8;
    localparam int ID_W = 4;

    logic            clk_pixel = 1'b0;
    logic            reset = 1'b1;
    logic            video_field_end = 1'b0;
    logic            packet_enable = 1'b0;
    logic [NU-1:0]   urgent_req = '0;
    logic [NP-1:0]   periodic_en = '0;
    logic [NU-1:0]   urgent_ack;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic            slot_active;
    logic            missed_field;
    logic            protocol_error;

    packet_slot_scheduler dut (
        .clk_pixel      (clk_pixel),
        .reset          (reset),
        .video_field_end(video_field_end),
        .packet_enable  (packet_enable),
        .urgent_req     (urgent_req),
        .periodic_en    (periodic_en),
        .urgent_ack     (urgent_ack),
        .grant_valid    (grant_valid),
        .grant_id       (grant_id),
        .slot_active    (slot_active),
        .missed_field   (missed_field),
        .protocol_error (protocol_error)
    );

    always #5 clk_pixel = ~clk_pixel;

    int tests = 0;
    int fails = 0;

    // Reference model: pending set, RR pointer, cycles of slot still in flight.
    bit [NP-1:0]     m_pend;
    int              m_ptr;
    int              m_left;
    bit              m_perr;
    int              m_streak;
    logic            e_gv;
    logic [NU-1:0]   e_ack;
    logic            e_missed;
    logic [ID_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_ptr = 0; m_left = 0; m_perr = 1'b0; m_streak = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic fe, input logic pe);
        int  u, p, k;
        bit  force_p;
        e_missed = fe && ((m_pend & periodic_en) != 0);
        if (fe) m_pend = periodic_en;
        e_gv  = 1'b0;
        e_ack = '0;
        if (pe && m_left > 0) m_perr = 1'b1;
        if (pe && m_left == 0) begin
            u = -1; p = -1;
            for (int i = 0; i < NU; i++) if (u < 0 && urgent_req[i]) u = i;
            for (int j = 0; j < NP; j++) begin
                k = (m_ptr + j) % NP;
                if (p < 0 && m_pend[k] && periodic_en[k]) p = k;
            end
            force_p = 1'b0;
`ifdef PACKET_SCHED_STARVATION_GUARD_EN
            force_p = (m_streak >= 4) && (p >= 0);
`endif
            e_gv = 1'b1;
            if (u >= 0 && !force_p) begin
                exp_q.push_back(ID_W'(u + 1));
                e_ack[u] = 1'b1;
                if (p >= 0) m_streak++;
            end else if (p >= 0) begin
                exp_q.push_back(ID_W'(NU + 1 + p));
                m_pend[p] = 1'b0;
                m_ptr = (p + 1) % NP;
                m_streak = 0;
            end else begin
                exp_q.push_back('0);
                m_streak = 0;
            end
            m_left = 32;
        end else if (m_left > 0) begin
            m_left--;
        end
    endtask

    // Drive one cycle of strobes, advance the model, then check all outputs.
    task automatic cyc(input logic fe, input logic pe);
        logic [ID_W-1:0] want;
        video_field_end = fe;
        packet_enable   = pe;
        model_step(fe, pe);
        @(posedge clk_pixel);
        #1;
        video_field_end = 1'b0;
        packet_enable   = 1'b0;
        chk("grant_valid", grant_valid, e_gv);
        chk("urgent_ack", urgent_ack, e_ack);
        chk("missed_field", missed_field, e_missed);
        chk("slot_active", slot_active, m_left > 0);
        chk("protocol_error", protocol_error, m_perr);
        if (grant_valid === 1'b1) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            chk("grant_id", grant_id, want);
        end
    endtask

    task automatic do_slot(input int exp_id);
        cyc(1'b0, 1'b1);
        chk("plan_grant_id", grant_id, exp_id);
        repeat (32) cyc(1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        video_field_end = 1'b0;
        packet_enable = 1'b0;
        urgent_req = '0;
        repeat (2) @(posedge clk_pixel);
        #1;
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_urgent_ack", urgent_ack, 0);
        chk("rst_slot_active", slot_active, 0);
        chk("rst_missed", missed_field, 0);
        chk("rst_protocol_error", protocol_error, 0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic fe, pe;
        model_reset();

        // Periodic round-robin then NULL once the field's work is done.
        apply_reset();
        periodic_en = 8'h0F;
        cyc(1'b1, 1'b0);
        do_slot(3); do_slot(4); do_slot(5); do_slot(6);
        do_slot(0);
        chk("null_grant_valid_seen", e_gv, 1'b0);

        // Urgent fixed priority ahead of pending periodic work.
        cyc(1'b1, 1'b0);
        urgent_req = 2'b11;
        do_slot(1);
        urgent_req = 2'b10;
        do_slot(2);
        urgent_req = 2'b00;
        do_slot(3);

        // Unfinished field reports a miss; pointer survives the reload.
        apply_reset();
        periodic_en = 8'h03;
        cyc(1'b1, 1'b0);
        do_slot(3);
        cyc(1'b1, 1'b0);
        chk("plan_missed_field", missed_field, 1);
        do_slot(4);

        // Strobe mid-slot is rejected and latches the error.
        cyc(1'b0, 1'b1);
        repeat (10) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("mid_slot_no_grant", grant_valid, 0);
        chk("mid_slot_error", protocol_error, 1);
        repeat (21) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("post_slot_grant", grant_valid, 1);
        repeat (32) cyc(1'b0, 1'b0);

        // Field end and strobe together: reload is seen by that arbitration.
        periodic_en = 8'h80;
        cyc(1'b1, 1'b1);
        chk("same_cycle_id", grant_id, 10);
        repeat (32) cyc(1'b0, 1'b0);

        // Urgent streak against waiting periodic work.
        apply_reset();
        periodic_en = 8'hFF;
        cyc(1'b1, 1'b0);
        urgent_req = 2'b01;
        repeat (4) do_slot(1);
`ifdef PACKET_SCHED_STARVATION_GUARD_EN
        do_slot(3);
`else
        do_slot(1);
`endif
        do_slot(1);

        // Randomized traffic.
        for (int seg = 0; seg < 3; seg++) begin
            apply_reset();
            periodic_en = NP'($urandom_range(0, 255));
            repeat (1200) begin
                if ($urandom_range(0, 15) == 0) urgent_req = NU'($urandom_range(0, 3));
                pe = (m_left == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
                fe = ($urandom_range(0, 199) == 0);
                cyc(fe, pe);
            end
        end

        chk("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
